conv_window_ctrl: RTL and testbench
===================================

Name: conv_window_ctrl

Overview:
Sequencer for the 3x3 convolution ALU. It walks a 3x3 window across an IMG_W x IMG_H 8-bit image held in a read-only pixel memory, and fetches the 9 pixels for each output position. It packs those pixels onto the ALU's line1/line2/line3 buses, pulses the ALU enable, and captures the one-cycle-valid 20-bit result. Each result is written to an output memory through a ready-qualified write port.

Parameters:
IMG_W, 8, image width in pixels (min 3)
IMG_H, 8, image height in pixels (min 3)
ADDR_W, 16, read/write address width
RD_BASE, 0, pixel memory address of pixel (0,0); row-major
WR_BASE, 0, output memory address of first result

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin one frame; sampled only in IDLE
filter_in  in  72  coefficients a..i (a = [7:0]); captured on accepted start
rd_en  out  1  pixel read strobe
rd_addr  out  ADDR_W  pixel address
rd_data  in  8  pixel; valid exactly 1 cycle after rd_en
filter_out  out  72  to ALU filter; holds captured coefficients
line1  out  24  to ALU; window row r: [7:0]=(r,c) [15:8]=(r,c+1) [23:16]=(r,c+2)
line2  out  24  same packing, row r+1
line3  out  24  same packing, row r+2
alu_en  out  1  to ALU enable; one-cycle pulse per window
alu_result  in  20  from ALU result
wr_en  out  1  output write request
wr_addr  out  ADDR_W  WR_BASE + output index (row-major over (IMG_W-2) x (IMG_H-2))
wr_data  out  20  convolution result
wr_ready  in  1  write accepted when wr_en && wr_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last write accepted

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0: rd_en, rd_addr, filter_out, line1-3, alu_en, wr_en, wr_addr, wr_data, busy, done. Window counters r and c reset to 0.
- IDLE:
  - start=1 captures filter_in into filter_out, clears r, c and out_idx, sets busy, goes to FETCH.
  - start is ignored in all other states.
- FETCH (9 cycles, k=0..8):
  - rd_en=1, rd_addr = RD_BASE + (r + k/3)*IMG_W + (c + k%3).
  - rd_data returned for k-1 is written into window slot k-1.
- WAIT (1 cycle): rd_en=0; the slot-8 pixel is captured.
- COMPUTE (1 cycle): alu_en=1. line1-3 hold all 9 pixels and stay stable through CAPTURE.
- CAPTURE (1 cycle): alu_en=0. alu_result is valid only in this cycle because the ALU clears its products when enable is low. Register it into wr_data, set wr_en=1, wr_addr = WR_BASE + out_idx.
- WRITE: hold wr_en, wr_addr and wr_data stable until wr_ready=1. On acceptance, wr_en drops next cycle and out_idx increments.
  - If c < IMG_W-3: c++, go to FETCH.
  - Else if r < IMG_H-3: c=0, r++, go to FETCH.
  - Else go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE. filter_out keeps its value until the next accepted start.
- Latency: 13 cycles per output with wr_ready tied high (9+1+1+1+1). The first rd_en is asserted the cycle after start is accepted.
- Width rule: results are unsigned 20-bit. The maximum is 9*255*255 = 585225 (0x8EE09); no saturation.
- No reads are issued while in WRITE, so backpressure stalls the whole pipeline.
- Reset mid-operation aborts immediately; no partial write completes. The next start restarts from window (0,0).
- wr_ready high outside WRITE has no effect.

Test Plan:
- Reset: assert rst=0 mid-frame -> all outputs 0 the same cycle. After release, no rd_en/wr_en until start.
- IMG_W=IMG_H=3, pixels 1..9 row-major, filter all 1, wr_ready=1 -> one write: wr_data=45, wr_addr=WR_BASE. done pulses; first read to done is 14 cycles.
- IMG_W=IMG_H=4, p(r,c)=4r+c, filter_in[39:32]=1, others 0 -> four writes: data 5, 6, 9, 10 at wr_addr 0..3. rd_addr sequence for window (0,1) is 1,2,3,5,6,7,9,10,11.
- IMG 3x3, all pixels 255, filter all 255 -> wr_data=0x8EE09 with no truncation.
- wr_ready held low 5 cycles on first write -> wr_en, wr_addr and wr_data stable for 6 cycles, rd_en=0 throughout, and the second window's reads start the cycle after acceptance.
- start pulsed while busy with a different filter_in -> ignored; filter_out and the result sequence are unchanged, and exactly one done pulse occurs.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: walks a 3x3 window over a row-major pixel memory, feeds the
// 3x3 convolution ALU and streams each result to an output memory.
module conv_window_ctrl #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int ADDR_W  = 16,
   parameter int RD_BASE = 0,
   parameter int WR_BASE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [71:0]       filter_in,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [71:0]       filter_out,
   output logic [23:0]       line1,
   output logic [23:0]       line2,
   output logic [23:0]       line3,
   output logic              alu_en,
   input  logic [19:0]       alu_result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [19:0]       wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_COMPUTE,
      S_CAPTURE,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(IMG_W - 3);
   localparam logic [ADDR_W-1:0] R_LAST    = ADDR_W'(IMG_H - 3);
   localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
   localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);

   state_t            state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [1:0]        kr_q, kr_d;
   logic [1:0]        kc_q, kc_d;
   logic [ADDR_W-1:0] r_q, r_d;
   logic [ADDR_W-1:0] c_q, c_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [71:0]       filt_q, filt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [19:0]       wr_data_q, wr_data_d;
   logic              pend_vld_q;
   logic [3:0]        pend_slot_q;
   logic [7:0]        win_q [9];
   logic [ADDR_W-1:0] fetch_addr;

   // kr/kc are the row/column offsets of fetch step k inside the window
   assign fetch_addr = RD_BASE_A + (r_q + ADDR_W'(kr_q)) * IMG_W_A + c_q + ADDR_W'(kc_q);

   assign filter_out = filt_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign line1      = {win_q[2], win_q[1], win_q[0]};
   assign line2      = {win_q[5], win_q[4], win_q[3]};
   assign line3      = {win_q[8], win_q[7], win_q[6]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         r_q         <= '0;
         c_q         <= '0;
         idx_q       <= '0;
         filt_q      <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         pend_vld_q  <= 1'b0;
         pend_slot_q <= '0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         kr_q        <= kr_d;
         kc_q        <= kc_d;
         r_q         <= r_d;
         c_q         <= c_d;
         idx_q       <= idx_d;
         filt_q      <= filt_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         // read data arrives one cycle after the strobe, so the slot trails k by one
         pend_vld_q  <= (state_q == S_FETCH);
         pend_slot_q <= k_q;
         if (pend_vld_q) win_q[pend_slot_q] <= rd_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      kr_d      = kr_q;
      kc_d      = kc_q;
      r_d       = r_q;
      c_d       = c_q;
      idx_d     = idx_q;
      filt_d    = filt_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_en     = 1'b0;
      rd_addr   = '0;
      alu_en    = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               filt_d  = filter_in;
               r_d     = '0;
               c_d     = '0;
               idx_d   = '0;
               k_d     = '0;
               kr_d    = '0;
               kc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            busy    = 1'b1;
            rd_en   = 1'b1;
            rd_addr = fetch_addr;
            if (k_q == 4'd8) begin
               k_d     = '0;
               kr_d    = '0;
               kc_d    = '0;
               state_d = S_WAIT;
            end else begin
               k_d = k_q + 4'd1;
               if (kc_q == 2'd2) begin
                  kc_d = '0;
                  kr_d = kr_q + 2'd1;
               end else begin
                  kc_d = kc_q + 2'd1;
               end
            end
         end
         S_WAIT: begin
            busy    = 1'b1;
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy    = 1'b1;
            alu_en  = 1'b1;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // the ALU result is only valid the cycle after its enable
            busy      = 1'b1;
            wr_data_d = alu_result;
            wr_addr_d = WR_BASE_A + idx_q;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            busy  = 1'b1;
            wr_en = 1'b1;
            if (wr_ready) begin
               idx_d = idx_q + ADDR_W'(1);
               if (c_q < C_LAST) begin
                  c_d     = c_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end else if (r_q < R_LAST) begin
                  c_d     = '0;
                  r_d     = r_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on a 4x4 image: pixel memory and ALU
// models around the DUT, results compared with a direct 3x3 convolution.
module tb_conv_window_ctrl;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int AW = 16;
   localparam int RB = 0;
   localparam int WB = 0;

   logic          clk;
   logic          rst;
   logic          start;
   logic [71:0]   filter_in;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [71:0]   filter_out;
   logic [23:0]   line1;
   logic [23:0]   line2;
   logic [23:0]   line3;
   logic          alu_en;
   logic [19:0]   alu_result;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [19:0]   wr_data;
   logic          wr_ready;
   logic          busy;
   logic          done;

   logic [7:0]    pix [W*H];
   logic [AW-1:0] rd_log [$];
   logic [AW-1:0] wa_log [$];
   logic [19:0]   wd_log [$];
   int            n_chk;
   int            n_pass;

   conv_window_ctrl #(
      .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_BASE(RB), .WR_BASE(WB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .filter_in(filter_in),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .filter_out(filter_out), .line1(line1), .line2(line2), .line3(line3),
      .alu_en(alu_en), .alu_result(alu_result),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
      int i;
      i = int'(a) - RB;
      if (i >= 0 && i < W*H) return pix[i];
      return 8'h00;
   endfunction

   // ALU: bytes of {line3,line2,line1} pair with coefficients a..i in order
   function automatic logic [19:0] alu_model(input logic [23:0] l1, input logic [23:0] l2,
                                             input logic [23:0] l3, input logic [71:0] f);
      logic [71:0] px;
      logic [19:0] s;
      px = {l3, l2, l1};
      s  = '0;
      for (int k = 0; k < 9; k++) s += 20'(px[8*k +: 8]) * 20'(f[8*k +: 8]);
      return s;
   endfunction

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem_rd(rd_addr);
         rd_log.push_back(rd_addr);
      end else begin
         rd_data <= 8'($urandom);
      end
      alu_result <= alu_en ? alu_model(line1, line2, line3, filter_out) : 20'd0;
      if (rst && wr_en && wr_ready) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
      end
   end

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic rst_checks(input string pfx);
      chk({pfx, "_ctl"}, 72'({rd_en, alu_en, wr_en, busy, done}), '0);
      chk({pfx, "_rd_addr"}, 72'(rd_addr), '0);
      chk({pfx, "_filter"}, filter_out, '0);
      chk({pfx, "_lines"}, 72'({line3, line2, line1}), '0);
      chk({pfx, "_wr_addr"}, 72'(wr_addr), '0);
      chk({pfx, "_wr_data"}, 72'(wr_data), '0);
   endtask

   function automatic logic [71:0] rand_f();
      return {8'($urandom), 32'($urandom), 32'($urandom)};
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < W*H; i++)
         pix[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
   endtask

   // mode 0: ready high, 1: random ready, 2: first write stalled 5 cycles,
   // 3: extra start pulses with another filter while busy
   task automatic run_frame(input logic [71:0] f, input int mode);
      int exp_rd [$];
      int exp_wa [$];
      int exp_wd [$];
      int s, cyc, first_rd, first_wr, last_rise, done_cyc, ndone;
      int busy_err, filt_err, stall_err, ovl, rerr, w0, n;
      logic prev_rd;
      logic [AW-1:0] hold_a;
      logic [19:0] hold_d;

      for (int r = 0; r <= H - 3; r++) begin
         for (int c = 0; c <= W - 3; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  s += int'(pix[(r+i)*W + c + j]) * int'(f[8*(3*i+j) +: 8]);
                  exp_rd.push_back(RB + (r+i)*W + c + j);
               end
            end
            exp_wd.push_back(s);
            exp_wa.push_back(WB + r*(W-2) + c);
         end
      end

      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
      first_rd = -1; first_wr = -1; last_rise = -1; done_cyc = -1; ndone = 0;
      busy_err = 0; filt_err = 0; stall_err = 0; ovl = 0; w0 = -1;
      prev_rd = 1'b0; hold_a = '0; hold_d = '0;

      @(negedge clk);
      start = 1'b1; filter_in = f; wr_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; filter_in = ~f;
      cyc = 1;
      forever begin
         if (rd_en && first_rd < 0) first_rd = cyc;
         if (rd_en && !prev_rd) last_rise = cyc;
         prev_rd = rd_en;
         if (wr_en && first_wr < 0) first_wr = cyc;
         if (rd_en && wr_en) ovl++;
         if (done === 1'b1) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc < 0) begin
            if (busy !== 1'b1) busy_err++;
         end else if (cyc == done_cyc && busy !== 1'b0) begin
            busy_err++;
         end
         if (filter_out !== f) filt_err++;
         if (mode == 2) begin
            if (w0 < 0 && wr_en) begin
               w0 = cyc; hold_a = wr_addr; hold_d = wr_data;
            end
            if (w0 >= 0 && cyc <= w0 + 5)
               if (!wr_en || wr_addr !== hold_a || wr_data !== hold_d || rd_en) stall_err++;
            if (w0 >= 0 && cyc == w0 + 6)
               if (wr_en || !rd_en) stall_err++;
            wr_ready = !(w0 >= 0 && cyc < w0 + 5);
         end else if (mode == 1) begin
            wr_ready = ($urandom_range(0, 3) != 0);
         end else begin
            wr_ready = 1'b1;
         end
         if (mode == 3) begin
            start     = (cyc == 5 || cyc == 13);
            filter_in = start ? ~f : f;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         if (cyc >= 3000) begin
            chk("timeout", 72'(cyc), 72'(0));
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      wr_ready = 1'b1;

      chk("n_writes", 72'(wd_log.size()), 72'(exp_wd.size()));
      n = (wd_log.size() < exp_wd.size()) ? wd_log.size() : exp_wd.size();
      for (int i = 0; i < n; i++) begin
         chk("wr_addr", 72'(wa_log[i]), 72'(exp_wa[i]));
         chk("wr_data", 72'(wd_log[i]), 72'(exp_wd[i]));
      end
      chk("n_reads", 72'(rd_log.size()), 72'(exp_rd.size()));
      rerr = 0;
      n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
      for (int i = 0; i < n; i++) if (rd_log[i] !== AW'(exp_rd[i])) rerr++;
      chk("rd_seq_errs", 72'(rerr), '0);
      chk("first_rd_cycle", 72'(first_rd), 72'(1));
      chk("done_pulses", 72'(ndone), 72'(1));
      chk("busy_errs", 72'(busy_err), '0);
      chk("filter_errs", 72'(filt_err), '0);
      chk("rd_wr_overlap", 72'(ovl), '0);
      if (mode == 0) begin
         chk("first_wr_lat", 72'(first_wr - first_rd), 72'(12));
         chk("done_lat", 72'(done_cyc - last_rise), 72'(13));
      end
      if (mode == 2) begin
         chk("stall_first_wr", 72'(w0), 72'(13));
         chk("stall_errs", 72'(stall_err), '0);
      end
   endtask

   task automatic abort_frame(input logic [71:0] f);
      int nw;
      @(negedge clk);
      start = 1'b1; filter_in = f;
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(3, 40)) @(negedge clk);
      rst = 1'b0;
      #1;
      rst_checks("abort");
      nw = wd_log.size();
      repeat (2) @(negedge clk);
      chk("abort_no_write", 72'(wd_log.size()), 72'(nw));
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_idle", 72'({rd_en, wr_en, busy}), '0);
      end
   endtask

   initial begin
      logic [19:0]   dir_wd [4];
      logic [AW-1:0] dir_rd [9];
      n_chk = 0; n_pass = 0;
      rst = 1'b1; start = 1'b0; filter_in = '0; wr_ready = 1'b0;
      #1 rst = 1'b0;
      #2;
      rst_checks("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1; wr_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_after_reset", 72'({rd_en, wr_en, busy}), '0);
      end

      // p(r,c) = 4r+c with only the centre coefficient set
      for (int i = 0; i < W*H; i++) pix[i] = 8'(4*(i/W) + i%W);
      run_frame(72'h1 << 32, 0);
      dir_wd = '{20'd5, 20'd6, 20'd9, 20'd10};
      dir_rd = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd11};
      chk("dir_count", 72'(wd_log.size()), 72'(4));
      for (int i = 0; i < 4 && i < wd_log.size(); i++) begin
         chk("dir_wr_data", 72'(wd_log[i]), 72'(dir_wd[i]));
         chk("dir_wr_addr", 72'(wa_log[i]), 72'(i));
      end
      chk("dir_rd_count", 72'(rd_log.size()), 72'(36));
      for (int i = 0; i < 9 && 9 + i < rd_log.size(); i++)
         chk("dir_rd_win01", 72'(rd_log[9+i]), 72'(dir_rd[i]));

      // largest possible result must pass through untruncated
      for (int i = 0; i < W*H; i++) pix[i] = 8'hFF;
      run_frame({9{8'hFF}}, 0);
      for (int i = 0; i < wd_log.size(); i++) chk("max_result", 72'(wd_log[i]), 72'(20'h8EE09));

      fill_rand();
      run_frame(rand_f(), 2);
      fill_rand();
      run_frame(rand_f(), 3);

      fill_rand();
      abort_frame(rand_f());
      run_frame(rand_f(), 0);

      for (int t = 0; t < 4; t++) begin
         fill_rand();
         run_frame(rand_f(), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
